cb_nway: RTL
============

CB_NWAY -- requirements
Module: cb_nway

Interface
REQ-001 SHALL have parameter DW, default 16, width of data token.
REQ-002 SHALL have parameter NOUT, default 4, number of branch outputs (2..16).
REQ-003 SHALL have parameter SELW, default 2, select width; SHALL satisfy 2**SELW >= NOUT.
REQ-004 CLK  input  1  sole clock, all state on rising edge.
REQ-005 MR  input  1  reset; synchronous and active-high.
REQ-006 CB_Send_in  input  1  upstream token valid.
REQ-007 CB_Ack_out  output  1  block can accept a token this cycle.
REQ-008 CB_Data_in  input  DW  token data.
REQ-009 CB_Sel_in  input  SELW  branch target index.
REQ-010 CB_Bcast_in  input  1  token goes to all outputs, ignoring CB_Sel_in.
REQ-011 CB_Send_out  output  NOUT  per-output token valid.
REQ-012 CB_Ack_in  input  NOUT  per-output downstream accept.
REQ-013 CB_Data_out  output  DW  head token data, shared by all outputs.
REQ-014 CB_CP  output  1  one-cycle pulse per accepted input token.
REQ-015 CB_Err  output  1  one-cycle pulse per dropped token.
REQ-016 CB_Drop_cnt  output  8  saturating count of dropped tokens.

Function
REQ-017 Input transfer SHALL occur on a cycle with CB_Send_in=1 and CB_Ack_out=1; output transfer on output i when CB_Send_out[i]=1 and CB_Ack_in[i]=1.
REQ-018 Tokens {data, sel, bcast} SHALL be held in a 2-entry in-order buffer; occupancy states EMPTY, ONE, TWO.
REQ-019 CB_Ack_out SHALL be 1 when occupancy is EMPTY or ONE, 0 in TWO; driven from registered state only, never from CB_Ack_in.
REQ-020 Latency: a token accepted at edge t SHALL appear on CB_Send_out/CB_Data_out in the cycle after t.
REQ-021 Route token (bcast=0, sel<NOUT): CB_Send_out[sel]=1, all other bits 0; retires on CB_Ack_in[sel]=1.
REQ-022 Broadcast token: CB_Send_out[i]=~done[i]; done[i] set on output-i transfer; token retires in the cycle the last pending output transfers; done cleared at retire.
REQ-023 Out-of-range token (bcast=0, sel>=NOUT): SHALL be dropped at acceptance, never enter the buffer; CB_Err pulses next cycle; CB_Drop_cnt increments, saturating at 255; CB_CP still pulses.
REQ-024 CB_CP SHALL pulse one cycle after every input transfer.
REQ-025 Transitions: accept only -> occupancy+1; retire only -> occupancy-1; accept and retire in the same cycle (ONE) -> stays ONE, new token becomes head next cycle.
REQ-026 Sustained throughput SHALL be one token per cycle when targeted outputs ack continuously.
REQ-027 CB_Send_out SHALL be all-zero when EMPTY; CB_Data_out holds last head value (don't-care).
REQ-028 A raised CB_Send_out bit SHALL stay high with stable data until its transfer.
REQ-029 CB_Ack_in on bits not currently asserted in CB_Send_out SHALL be ignored.

Reset
REQ-030 While MR=1 at an edge: occupancy EMPTY, done mask 0, CB_Send_out 0, CB_Ack_out 0, CB_CP 0, CB_Err 0, CB_Drop_cnt 0.
REQ-031 CB_Ack_out SHALL be 1 in the first cycle after MR deasserts.
REQ-032 MR asserted mid-operation SHALL discard all buffered tokens and partial broadcast state; no transfer completes at that edge.

Verification
REQ-033 Route: NOUT=4, send data 0x1234 sel=2, Ack_in=4'b0100 -> next cycle Send_out=4'b0100, Data_out=0x1234, CB_CP pulse, retire same cycle.
REQ-034 Broadcast partial: bcast=1, Ack_in=4'b0011 then 4'b1100 -> Send_out 4'b1111 then 4'b1100 then 0; single retire.
REQ-035 Backpressure: Ack_in=0, send 3 tokens back-to-back -> Ack_out low after 2nd; 3rd held upstream; release Ack -> order preserved.
REQ-036 Drop: NOUT=3, sel=3 -> no Send_out, CB_Err pulse, Drop_cnt=1; 300 drops -> Drop_cnt=255.
REQ-037 Streaming: 16 tokens, alternating sel 0/1, Ack_in all 1 -> one token out per cycle, no bubbles.
REQ-038 Reset mid-broadcast: MR=1 with done=4'b0011 -> Send_out=0, Ack_out=0; after MR drops Ack_out=1, EMPTY.

Source files
------------

// File: rtl/cb_nway_if.sv
// cb_nway_if: upstream token, per-branch handshake and status signals of cb_nway.
interface cb_nway_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NOUT = 4,
  parameter int unsigned SELW = 2
);
  logic            CB_Send_in;
  logic            CB_Ack_out;
  logic [DW-1:0]   CB_Data_in;
  logic [SELW-1:0] CB_Sel_in;
  logic            CB_Bcast_in;
  logic [NOUT-1:0] CB_Send_out;
  logic [NOUT-1:0] CB_Ack_in;
  logic [DW-1:0]   CB_Data_out;
  logic            CB_CP;
  logic            CB_Err;
  logic [7:0]      CB_Drop_cnt;

  // Environment side: produces tokens and downstream acks.
  modport master (
    output CB_Send_in, CB_Data_in, CB_Sel_in, CB_Bcast_in, CB_Ack_in,
    input  CB_Ack_out, CB_Send_out, CB_Data_out, CB_CP, CB_Err, CB_Drop_cnt
  );

  // Block side.
  modport slave (
    input  CB_Send_in, CB_Data_in, CB_Sel_in, CB_Bcast_in, CB_Ack_in,
    output CB_Ack_out, CB_Send_out, CB_Data_out, CB_CP, CB_Err, CB_Drop_cnt
  );
endinterface

// File: rtl/cb_nway.sv
// cb_nway: 2-entry in-order token buffer that routes each token to one of
// NOUT branches or broadcasts it to all of them; out-of-range tokens are dropped.
module cb_nway #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NOUT = 4,
  parameter int unsigned SELW = 2
) (
  input logic      CLK,
  input logic      MR,
  cb_nway_if.slave cb
);

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [SELW-1:0] sel;
    logic            bcast;
  } tok_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t            r_occ;
  occ_t            w_occ_nxt;
  tok_t            r_head;
  tok_t            r_tail;
  logic [NOUT-1:0] r_done;
  logic            r_ack_out;
  logic            r_cp;
  logic            r_err;
  logic [7:0]      r_drop_cnt;

  tok_t            w_in_tok;
  logic            w_in_xfer;
  logic            w_oor;
  logic            w_push;
  logic            w_retire;
  logic [NOUT-1:0] w_send;
  logic [NOUT-1:0] w_fire;

  assign w_in_tok  = '{data: cb.CB_Data_in, sel: cb.CB_Sel_in, bcast: cb.CB_Bcast_in};
  assign w_in_xfer = cb.CB_Send_in & r_ack_out;
  assign w_oor     = ~cb.CB_Bcast_in && (32'(cb.CB_Sel_in) >= NOUT);
  assign w_push    = w_in_xfer & ~w_oor;

  // Head valid mask: pending branches for a broadcast, one-hot select for a route.
  always_comb begin
    w_send = '0;
    if (r_occ != EMPTY) begin
      if (r_head.bcast) begin
        w_send = ~r_done;
      end else begin
        for (int unsigned i = 0; i < NOUT; i++) begin
          w_send[i] = (32'(r_head.sel) == i);
        end
      end
    end
  end

  assign w_fire = w_send & cb.CB_Ack_in;

  // Head retires once every targeted branch has transferred.
  always_comb begin
    w_retire = 1'b0;
    if (r_occ != EMPTY) begin
      w_retire = r_head.bcast ? &(r_done | w_fire) : |w_fire;
    end
  end

  // Occupancy state register.
  always_ff @(posedge CLK) begin
    if (MR) begin
      r_occ <= EMPTY;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  // Occupancy next state: push and retire in the same cycle leave it unchanged.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_retire})
      2'b10:   w_occ_nxt = (r_occ == EMPTY) ? ONE : TWO;
      2'b01:   w_occ_nxt = (r_occ == TWO) ? ONE : EMPTY;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Token storage: head shifts from tail on retire, new token fills the first free slot.
  always_ff @(posedge CLK) begin
    if (!MR) begin
      if (w_push && (r_occ == EMPTY || w_retire)) begin
        r_head <= w_in_tok;
      end else if (w_retire) begin
        r_head <= r_tail;
      end
      if (w_push && r_occ == ONE && !w_retire) begin
        r_tail <= w_in_tok;
      end
    end
  end

  // Broadcast progress, upstream ready and status pulses/counter.
  always_ff @(posedge CLK) begin
    if (MR) begin
      r_done     <= '0;
      r_ack_out  <= 1'b0;
      r_cp       <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ack_out <= (w_occ_nxt != TWO);
      r_cp      <= w_in_xfer;
      r_err     <= w_in_xfer & w_oor;
      if (w_in_xfer && w_oor && r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_retire) begin
        r_done <= '0;
      end else if (r_occ != EMPTY && r_head.bcast) begin
        r_done <= r_done | w_fire;
      end
    end
  end

  assign cb.CB_Ack_out  = r_ack_out;
  assign cb.CB_Send_out = w_send;
  assign cb.CB_Data_out = r_head.data;
  assign cb.CB_CP       = r_cp;
  assign cb.CB_Err      = r_err;
  assign cb.CB_Drop_cnt = r_drop_cnt;

endmodule
